// File: rtl/i2c_pkg.sv
// Shared I2C constants: address width, R/W polarity, master and target state encodings.
`timescale 1ns/1ps
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  // master sequencer states
  localparam logic [3:0] M_IDLE  = 4'd0;
  localparam logic [3:0] M_START = 4'd1;
  localparam logic [3:0] M_ADDR  = 4'd2;
  localparam logic [3:0] M_DATA  = 4'd3;
  localparam logic [3:0] M_ACK   = 4'd4;
  localparam logic [3:0] M_STOP  = 4'd5;

  // target (slave) states, visible on the debug port
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ACK_ADDR  = 4'd2;
  localparam logic [3:0] S_RX        = 4'd3;
  localparam logic [3:0] S_ACK_DATA  = 4'd4;
  localparam logic [3:0] S_TX        = 4'd5;
  localparam logic [3:0] S_MACK      = 4'd6;
  localparam logic [3:0] S_WAIT_STOP = 4'd7;

  function automatic logic is_busy_state(input logic [3:0] s);
    return (s >= S_ACK_ADDR) && (s <= S_MACK);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input stage: synchronizes sclk/sda, keeps one history sample, and registers
// edge and START/STOP pulses so every event reaches the FSM 3 clk after the bus edge.
`timescale 1ns/1ps
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sda,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] sclk_sync;
  logic [1:0] sda_sync;
  logic       sclk_h;
  logic       sda_h;

  // Idle bus is high: resetting to 1 avoids spurious edges after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= 2'b11;
      sda_sync  <= 2'b11;
      sclk_h    <= 1'b1;
      sda_h     <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sda_sync  <= {sda_sync[0], sda};
      sclk_h    <= sclk_sync[1];
      sda_h     <= sda_sync[1];
      sclk_rise <= sclk_sync[1] & ~sclk_h;
      sclk_fall <= ~sclk_sync[1] & sclk_h;
      // sclk must be high in both samples; a simultaneous sclk/sda change is a data edge
      start_det <= sclk_sync[1] & sclk_h & sda_h & ~sda_sync[1];
      stop_det  <= sclk_sync[1] & sclk_h & ~sda_h & sda_sync[1];
      sda_s     <= sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled bus front end, 7-bit address match and a parallel byte interface.
//   state      | meaning
//   IDLE       | waiting for START
//   ADDR       | shifting 7 address bits + R/W on sclk rise
//   ACK_ADDR   | mismatch -> WAIT_STOP; match -> ack low for the 9th bit
//   RX         | shifting a write byte on sclk rise
//   ACK_DATA   | ack low for the 9th bit, then next RX byte
//   TX         | tx_req + load at entry, bits presented on sclk fall
//   MACK       | released, sampling master ack/nack
//   WAIT_STOP  | released, ignoring bus until START/STOP
`timescale 1ns/1ps
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [3:0] state
);

  logic       sclk_rise;
  logic       sclk_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shift_in;
  logic       addr_match;
  logic       rw;
  logic       ack_phase;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sda       (sda_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign shift_in = {shreg[6:0], sda_s};
  assign busy     = addr_match && is_busy_state(state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      sda_out    <= 1'b1;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det || stop_det) begin
        state      <= start_det ? S_ADDR : S_IDLE;
        bit_cnt    <= 3'd0;
        shreg      <= 8'h00;
        sda_out    <= 1'b1;
        addr_match <= 1'b0;
        ack_phase  <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (sclk_rise) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state      <= S_ACK_ADDR;
                addr_match <= (shift_in[7:1] == ADDR);
                rw         <= shift_in[0];
                ack_phase  <= 1'b0;
              end
            end
          end
          S_ACK_ADDR: begin
            if (!addr_match) begin
              state <= S_WAIT_STOP;
            end else if (sclk_fall) begin
              if (!ack_phase) begin
                sda_out   <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (rw == I2C_WRITE) begin
                  state   <= S_RX;
                  sda_out <= 1'b1;
                end else begin
                  // ack stays low until the first read bit replaces it
                  state  <= S_TX;
                  tx_req <= 1'b1;
                end
              end
            end
          end
          S_RX: begin
            if (sclk_rise) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= shift_in;
                rx_valid  <= 1'b1;
                state     <= S_ACK_DATA;
                ack_phase <= 1'b0;
              end
            end
          end
          S_ACK_DATA: begin
            if (sclk_fall) begin
              if (!ack_phase) begin
                sda_out   <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                sda_out   <= 1'b1;
                ack_phase <= 1'b0;
                state     <= S_RX;
              end
            end
          end
          S_TX: begin
            if (tx_req) begin
              shreg   <= tx_data;
              sda_out <= tx_data[7];
            end else if (sclk_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
              if (bit_cnt == 3'd7) begin
                sda_out   <= 1'b1;
                state     <= S_MACK;
                ack_phase <= 1'b0;
              end else begin
                sda_out <= shreg[6];
              end
            end
          end
          S_MACK: begin
            if (sclk_rise) begin
              if (!sda_s) ack_phase <= 1'b1;
              else        state     <= S_WAIT_STOP;
            end else if (sclk_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              state     <= S_TX;
              tx_req    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) that sits directly downstream of `master` on the split-wire I2C bus, consuming its `sclk`/`sda_out`. It produces the acknowledge and read-data bits the master samples on `sda_in`. It oversamples the bus on the system clock and detects START/STOP. It matches a 7-bit address, then moves bytes between the bus and a simple parallel byte interface. It replaces hand-written bus responses in benches and is the target side of the synthesizable design.

## Interface
- `ADDR`, 7'h50: 7-bit device address matched after START.
- `clk` in 1: system clock; must be ≥ 8× `sclk` rate.
- `rst` in 1: asynchronous, active-low reset.
- `sclk` in 1: bus clock from master (asynchronous to `clk`).
- `sda_in` in 1: bus data from master (`master.sda_out`).
- `sda_out` in… out 1: bus data to master (`master.sda_in`); 1 = released, 0 = driven low.
- `tx_data` in 8: byte returned on a read; sampled when `tx_req` pulses.
- `tx_req` out 1: one-cycle pulse; `tx_data` captured this cycle.
- `rx_data` out 8: last byte written by master.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high from address match to STOP/mismatch.
- `state` out 4: current FSM state, for debug/bench.

## Operation
- Input stage: 2-flop synchronizers on `sclk`, `sda_in`, plus one history flop each. Rise/fall are derived from the last two synchronized samples.
- START: `sda` falls while `sclk` is high in both samples. STOP: `sda` rises under the same condition.
  - If `sclk` and `sda` change in the same sample, treat it as a data edge, not START/STOP.
  - START/STOP take priority over all other FSM activity.
- States (in `state` encoding):
  - IDLE=0
  - ADDR=1: shift 8 bits MSB-first on `sclk` rise: 7 address bits, then R/W (1 = read).
  - ACK_ADDR=2: on mismatch → WAIT_STOP, `sda_out` stays 1. On match, at next `sclk` fall drive `sda_out`=0 for one bit period. Then go to RX (W) or TX (R).
  - RX=3: sample 8 bits on `sclk` rise. After the 8th, update `rx_data` and pulse `rx_valid`.
  - ACK_DATA=4: drive ack low for one bit period, then → RX.
  - TX=5: pulse `tx_req` and load shifter at entry. Present each bit MSB-first, updated on `sclk` fall.
  - MACK=6: release `sda_out`, sample master ack on `sclk` rise. Ack (0) → TX with new byte; nack (1) → WAIT_STOP.
  - WAIT_STOP=7: `sda_out`=1, wait for START/STOP.
- Any START from any state → ADDR with the bit counter cleared (repeated START). Any STOP → IDLE.
- `busy` is high in states 2–6 after a match.
- The bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset values: `sda_out`=1, `tx_req`=0, `rx_valid`=0, `rx_data`=8'h00, `busy`=0, `state`=IDLE. All internal shifters and counters are 0.
- Reset mid-transfer: immediate release of `sda_out`. After reset deassertion, stay in IDLE until the next START.
- Bus-to-decision latency: 3 `clk` from a bus edge (2 sync + 1 edge register). `sda_out` changes on the following `clk` edge, i.e. 4 `clk` after the `sclk` fall.
- `sda_out` changes only after a detected `sclk` fall, never while `sclk` is high.
- `rx_valid` and `tx_req` are single-cycle pulses, never back-to-back within one byte.

## Structure
- Shared package `i2c_pkg`:
  - slave state localparams (4-bit, values above) alongside the existing master state constants;
  - `I2C_ADDR_W`=7;
  - R/W polarity constants `I2C_READ`=1, `I2C_WRITE`=0.
- Sub-module `i2c_bus_sync`: synchronizers, history flops, outputs `sclk_rise`, `sclk_fall`, `start_det`, `stop_det`, `sda_s`. It is reusable by the master.

## Test plan
- Write 0x50+W, then byte 0xA6, then STOP:
  - ack low during both 9th bits;
  - `rx_data`=8'hA6 with one `rx_valid` pulse;
  - `state` returns to IDLE.
- Read 0x50+R with `tx_data`=8'hF6, master nacks:
  - bus bits are 1,1,1,1,0,1,1,0;
  - one `tx_req` pulse;
  - `state` → WAIT_STOP, then IDLE on STOP.
- Address 0x51: `sda_out` stays 1 for the whole transfer, `busy`=0, no `rx_valid`.
- Two-byte read with master ack after byte 1 (`tx_data` 8'h12 then 8'h34): two `tx_req` pulses and bus data 0x12, 0x34.
- Repeated START after write of 0x5A, followed by 0x50+R: `rx_data`=8'h5A, new address phase acked, TX entered.
- `rst` pulled low mid-RX at bit 4: `sda_out`=1 within one `clk`, `state`=IDLE. The following full write of 0x3C still succeeds.
